// File: rtl/cam_response_resolver.sv
// cam_response_resolver
// Captures the CAM mismatch vector as a responder tag set, reports how many
// responders there are, then hands responder word addresses out one per
// valid/ready handshake in ascending order. A one-cycle done pulse follows
// the final hand-off; abort drops everything and returns to idle silently.
module cam_response_resolver #(
    parameter int WORDS  = 100,
    parameter int ADDR_W = 7      // 2**ADDR_W must exceed WORDS so the count fits
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORDS-1:0]  mismatch_in,
    input  logic              resp_ready,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_last,
    output logic              busy,
    output logic              done,
    output logic              any_resp,
    output logic [ADDR_W-1:0] resp_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WORDS-1:0]   tag_q, tag_d;
    logic [ADDR_W-1:0]  count_q, count_d;
    logic               any_q, any_d;

    // A responder is a word that matched, i.e. its mismatch line is low.
    logic [WORDS-1:0]   capture_vec;
    logic [ADDR_W-1:0]  capture_cnt;

    // Lowest pending responder and a one-hot mask selecting it in the tag.
    logic [ADDR_W-1:0]  lowest_addr;
    logic [WORDS-1:0]   lowest_mask;
    logic               single_left;
    logic               handshake;

    // Invert the mismatch lines into the candidate responder set.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_capture
            assign capture_vec[gi] = ~mismatch_in[gi];
        end
    endgenerate

    // Population count of the candidate set; WORDS fits in ADDR_W bits.
    always_comb begin
        capture_cnt = '0;
        for (int i = 0; i < WORDS; i++) begin
            capture_cnt = capture_cnt + ADDR_W'(capture_vec[i]);
        end
    end

    // Priority encoder: scan high to low so the lowest set bit wins last.
    always_comb begin
        lowest_addr = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (tag_q[i]) begin
                lowest_addr = ADDR_W'(i);
            end
        end
    end

    // One-hot mask of the word being presented, used to retire it.
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_mask
            assign lowest_mask[gi] = (lowest_addr == ADDR_W'(gi));
        end
    endgenerate

    // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
    assign single_left = (tag_q != '0) && ((tag_q & (tag_q - 1'b1)) == '0);

    assign resp_valid = (state_q == ST_SCAN);
    assign resp_addr  = (state_q == ST_SCAN) ? lowest_addr : '0;
    assign resp_last  = (state_q == ST_SCAN) && single_left;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign any_resp   = any_q;
    assign resp_count = count_q;
    assign handshake  = resp_valid && resp_ready;

    // Next-state logic: capture on start, retire one responder per handshake,
    // abort overrides everything except the held count/any_resp summary.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        count_d = count_q;
        any_d   = any_q;

        if (abort) begin
            state_d = ST_IDLE;
            tag_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tag_d   = capture_vec;
                        count_d = capture_cnt;
                        any_d   = (capture_cnt != '0);
                        state_d = (capture_cnt != '0) ? ST_SCAN : ST_DONE;
                    end
                end
                ST_SCAN: begin
                    if (handshake) begin
                        tag_d = tag_q & ~lowest_mask;
                        if (single_left) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    tag_d   = '0;
                end
            endcase
        end
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            count_q <= '0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            count_q <= count_d;
            any_q   <= any_d;
        end
    end

endmodule

// File: tb/tb_cam_response_resolver.sv
// Directed bench for cam_response_resolver: hand-computed responder sets,
// outputs sampled on the falling edge, inputs driven on the falling edge.
module tb_cam_response_resolver;

    localparam int WORDS  = 100;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [WORDS-1:0]  mismatch_in;
    logic              resp_ready;
    logic              resp_valid;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_last;
    logic              busy;
    logic              done;
    logic              any_resp;
    logic [ADDR_W-1:0] resp_count;

    int checks = 0;
    int errors = 0;

    cam_response_resolver #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .mismatch_in (mismatch_in),
        .resp_ready  (resp_ready),
        .resp_valid  (resp_valid),
        .resp_addr   (resp_addr),
        .resp_last   (resp_last),
        .busy        (busy),
        .done        (done),
        .any_resp    (any_resp),
        .resp_count  (resp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and return at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input int cnt, input logic any);
        check_val({tag, ".valid"}, 32'(resp_valid), 0);
        check_val({tag, ".addr"},  32'(resp_addr),  0);
        check_val({tag, ".last"},  32'(resp_last),  0);
        check_val({tag, ".busy"},  32'(busy),       0);
        check_val({tag, ".done"},  32'(done),       0);
        check_val({tag, ".any"},   32'(any_resp),   32'(any));
        check_val({tag, ".count"}, 32'(resp_count), 32'(cnt));
    endtask

    task automatic check_resp(input string tag, input int addr, input logic last);
        check_val({tag, ".valid"}, 32'(resp_valid), 1);
        check_val({tag, ".addr"},  32'(resp_addr),  32'(addr));
        check_val({tag, ".last"},  32'(resp_last),  32'(last));
        check_val({tag, ".done"},  32'(done),       0);
        $display("  %s: valid addr=%0d last=%0d ready=%0d", tag, resp_addr, resp_last, resp_ready);
    endtask

    task automatic check_done(input string tag, input int cnt, input logic any);
        check_val({tag, ".done"},  32'(done),       1);
        check_val({tag, ".busy"},  32'(busy),       1);
        check_val({tag, ".valid"}, 32'(resp_valid), 0);
        check_val({tag, ".count"}, 32'(resp_count), 32'(cnt));
        check_val({tag, ".any"},   32'(any_resp),   32'(any));
        $display("  %s: done count=%0d any=%0d", tag, resp_count, any_resp);
    endtask

    logic [WORDS-1:0] set14;
    logic [WORDS-1:0] set5;
    int               done_seen;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        mismatch_in = '1; resp_ready = 1'b0;
        set14 = '1; set14[1] = 1'b0; set14[4] = 1'b0;
        set5  = '1; set5[2] = 1'b0; set5[7] = 1'b0; set5[30] = 1'b0;
        set5[64] = 1'b0; set5[99] = 1'b0;

        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset", 0, 1'b0);

        // 1: words 1 and 4 respond, consumer always ready
        mismatch_in = set14; resp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; mismatch_in = '1;
        check_resp("t1.a", 1, 1'b0);
        check_val("t1.busy", 32'(busy), 1);
        check_val("t1.count", 32'(resp_count), 2);
        check_val("t1.any", 32'(any_resp), 1);
        tick();
        check_resp("t1.b", 4, 1'b1);
        tick();
        check_done("t1.done", 2, 1'b1);
        tick();
        check_idle("t1.idle", 2, 1'b1);

        // 2: same set with back-pressure for three cycles
        mismatch_in = set14; resp_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; mismatch_in = '1;
        for (int i = 0; i < 3; i++) begin
            check_resp("t2.hold", 1, 1'b0);
            tick();
        end
        resp_ready = 1'b1;
        check_resp("t2.a", 1, 1'b0);
        tick();
        check_resp("t2.b", 4, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_seen++;
        end
        check_val("t2.done_count", 32'(done_seen), 1);
        check_idle("t2.idle", 2, 1'b1);

        // 3: empty responder set
        mismatch_in = '1; start = 1'b1;
        tick();
        start = 1'b0;
        check_done("t3.done", 0, 1'b0);
        tick();
        check_idle("t3.idle", 0, 1'b0);

        // 4: every word responds
        mismatch_in = '0; resp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; mismatch_in = '1;
        check_val("t4.count", 32'(resp_count), 100);
        for (int i = 0; i < WORDS; i++) begin
            check_resp($sformatf("t4.w%0d", i), i, (i == WORDS - 1));
            tick();
        end
        check_done("t4.done", 100, 1'b1);
        tick();
        check_idle("t4.idle", 100, 1'b1);

        // 5: abort after two of five delivered; start in SCAN ignored
        mismatch_in = set5; resp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; mismatch_in = '1;
        check_val("t5.count", 32'(resp_count), 5);
        check_resp("t5.a", 2, 1'b0);
        tick();
        check_resp("t5.b", 7, 1'b0);
        tick();
        check_resp("t5.c", 30, 1'b0);
        resp_ready = 1'b0; start = 1'b1; mismatch_in = '0;
        tick();
        start = 1'b0; mismatch_in = '1;
        check_resp("t5.ignored_start", 30, 1'b0);
        check_val("t5.count_held", 32'(resp_count), 5);
        abort = 1'b1; resp_ready = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("t5.abort", 5, 1'b1);
        tick();
        check_idle("t5.after", 5, 1'b1);
        // abort beats start in IDLE
        mismatch_in = set14; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0; mismatch_in = '1;
        check_idle("t5.abort_start", 5, 1'b1);

        // 6: reset in the middle of a scan
        mismatch_in = set14; resp_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; mismatch_in = '1;
        check_resp("t6.scan", 1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("t6.reset", 0, 1'b0);
        mismatch_in = set14; resp_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; mismatch_in = '1;
        check_resp("t6.a", 1, 1'b0);
        tick();
        check_resp("t6.b", 4, 1'b1);
        tick();
        check_done("t6.done", 2, 1'b1);
        tick();
        check_idle("t6.idle", 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
